// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding and default width.
package serial_adder_pkg;

   localparam int DEFAULT_WIDTH = 4;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_SHIFT = 2'd1;
   localparam logic [1:0] ST_DONE  = 2'd2;

endpackage : serial_adder_pkg

// File: rtl/serial_adder_full_adder.sv
// Gate-level one-bit full adder; port order matches the full_subtractor cell.
module full_adder (
   output logic COUT,
   output logic S,
   input  logic A,
   input  logic B,
   input  logic CIN
);

   logic ab_x;
   logic ab_a;
   logic cx_a;

   xor g_x1 (ab_x, A, B);
   xor g_x2 (S, ab_x, CIN);
   and g_a1 (ab_a, A, B);
   and g_a2 (cx_a, ab_x, CIN);
   or  g_o1 (COUT, ab_a, cx_a);

endmodule : full_adder

// File: rtl/serial_adder.sv
// Bit-serial adder: accepts (A, B, CIN) per handshake, resolves it LSB-first through one
// full-adder cell over WIDTH cycles, and presents S/COUT through an output handshake.
module serial_adder
   import serial_adder_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             CIN,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] S,
   output logic             COUT,
   output logic             busy
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   logic [1:0]       state;
   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic [WIDTH-1:0] s_sh;
   logic             carry;
   logic [CW-1:0]    count;
   logic             fa_s;
   logic             fa_c;
   logic [WIDTH-1:0] s_next;
   logic             accept;
   logic             last_bit;

   full_adder u_fa (
      .COUT (fa_c),
      .S    (fa_s),
      .A    (a_sh[0]),
      .B    (b_sh[0]),
      .CIN  (carry)
   );

   // Sum bits enter at the MSB so the first (LSB) result ends up at bit 0.
   assign s_next   = {fa_s, s_sh[WIDTH-1:1]};
   assign in_ready = (state == ST_IDLE) & ~rst;
   assign busy     = (state != ST_IDLE);
   assign accept   = in_valid & in_ready;
   assign last_bit = (state == ST_SHIFT) && (count == LAST);

   // Operand/sum shift registers, carry flop and bit counter.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_sh  <= '0;
         b_sh  <= '0;
         s_sh  <= '0;
         carry <= 1'b0;
         count <= '0;
      end else if (accept) begin
         a_sh  <= A;
         b_sh  <= B;
         s_sh  <= '0;
         carry <= CIN;
         count <= '0;
      end else if (state == ST_SHIFT) begin
         a_sh  <= {1'b0, a_sh[WIDTH-1:1]};
         b_sh  <= {1'b0, b_sh[WIDTH-1:1]};
         s_sh  <= s_next;
         carry <= fa_c;
         count <= count + CW'(1);
      end else begin
         a_sh  <= a_sh;
         b_sh  <= b_sh;
         s_sh  <= s_sh;
         carry <= carry;
         count <= count;
      end
   end

   // Control FSM and registered result outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= ST_IDLE;
         S         <= '0;
         COUT      <= 1'b0;
         out_valid <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  state <= ST_SHIFT;
               end else begin
                  state <= ST_IDLE;
               end
            end
            ST_SHIFT: begin
               if (last_bit) begin
                  S         <= s_next;
                  COUT      <= fa_c;
                  out_valid <= 1'b1;
                  state     <= ST_DONE;
               end else begin
                  state <= ST_SHIFT;
               end
            end
            ST_DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  state     <= ST_IDLE;
               end else begin
                  state <= ST_DONE;
               end
            end
            default: begin
               out_valid <= 1'b0;
               state     <= ST_IDLE;
            end
         endcase
      end
   end

endmodule : serial_adder
